fifo_uart_tx: RTL and testbench

UART transmitter that drains the telemetry byte FIFO sitting directly upstream of it. It connects to the FIFO read port and pops one byte whenever the FIFO is non-empty and the block is idle and enabled. It accounts for the FIFO's one-cycle registered read latency and serialises the byte onto the board TX pin at a fixed baud rate. Frame format is selectable at elaboration time: 8 data bits, optional parity, 1 or 2 stop bits.

---
 rtl/fifo_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmitter that pops bytes from an upstream FIFO
//               (one-cycle registered read) and serialises them 8-bit LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLK_HZ    = 27000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int c_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int c_STOP_LEN     = STOP_BITS * c_CLKS_PER_BIT;
    localparam int c_CNT_W        = $clog2(c_STOP_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(c_STOP_LEN - 1);

    generate
        if (c_CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            PARITY < 0 || PARITY > 2) begin : g_bad_params
            $error("fifo_uart_tx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_PAR   = 3'd5,
        S_STOP  = 3'd6
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [2:0]           r_idx,    w_idx_nxt;
    logic [7:0]           r_shift,  w_shift_nxt;
    logic                 r_par,    w_par_nxt;
    logic                 r_tx,     w_tx_nxt;
    logic                 r_rd_en,  w_rd_en_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic [15:0]          r_frames_sent, w_frames_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_tx          <= 1'b1;
            r_rd_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_par         <= w_par_nxt;
            r_tx          <= w_tx_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_busy        <= w_busy_nxt;
            r_frames_sent <= w_frames_nxt;
        end
    end

    // Next-state logic computes the value every output register takes next,
    // so tx/busy/fifo_rd_en change exactly on the state transition edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_tx_nxt     = r_tx;
        w_rd_en_nxt  = 1'b0;
        w_busy_nxt   = r_busy;
        w_frames_nxt = r_frames_sent;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (en && !fifo_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nxt = fifo_rd_data;
                w_par_nxt   = (^fifo_rd_data) ^ (PARITY == 2);
                w_tx_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        if (PARITY != 0) begin
                            w_tx_nxt    = r_par;
                            w_state_nxt = S_PAR;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PAR: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == c_STOP_LAST) begin
                    w_cnt_nxt    = '0;
                    w_frames_nxt = r_frames_sent + 16'd1;
                    w_busy_nxt   = 1'b0;
                    w_tx_nxt     = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx          = r_tx;
    assign fifo_rd_en  = r_rd_en;
    assign busy        = r_busy;
    assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Scoreboard bench for fifo_uart_tx in 8N1, 8E1, 8O1 and 8N2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_CPB = 10;

    typedef struct {
        int         k;
        logic [11:0] bits;
        int         nbits;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  en_w = '0;
    logic [3:0]  empty_w;
    logic [3:0]  rd_en_w;
    logic [3:0]  tx_w;
    logic [3:0]  busy_w;
    logic [7:0]  rd_data [4];
    logic [15:0] frames_w [4];
    logic [3:0]  mon_en = 4'hF;

    logic [7:0]  fmem [4][16];
    int          wptr [4];
    int          rptr [4];
    int          pops [4];
    int          bad_pops [4];
    int          last_end [4];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .en(en_w[0]), .fifo_empty(empty_w[0]), .fifo_rd_en(rd_en_w[0]),
        .fifo_rd_data(rd_data[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frames_sent(frames_w[0]));
    fifo_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en_w[1]), .fifo_empty(empty_w[1]), .fifo_rd_en(rd_en_w[1]),
        .fifo_rd_data(rd_data[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frames_sent(frames_w[1]));
    fifo_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .en(en_w[2]), .fifo_empty(empty_w[2]), .fifo_rd_en(rd_en_w[2]),
        .fifo_rd_data(rd_data[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frames_sent(frames_w[2]));
    fifo_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .en(en_w[3]), .fifo_empty(empty_w[3]), .fifo_rd_en(rd_en_w[3]),
        .fifo_rd_data(rd_data[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frames_sent(frames_w[3]));

    // FIFO models with one-cycle registered read data
    always_comb begin
        empty_w = '0;
        for (int k = 0; k < 4; k++) empty_w[k] = (wptr[k] == rptr[k]);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rptr[k] = 0; pops[k] = 0; bad_pops[k] = 0; rd_data[k] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rd_en_w[k]) begin
                pops[k] <= pops[k] + 1;
                if (wptr[k] != rptr[k]) begin
                    rd_data[k] <= fmem[k][rptr[k] % 16];
                    rptr[k]    <= rptr[k] + 1;
                end else begin
                    bad_pops[k] <= bad_pops[k] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic push(input int k, input logic [7:0] b);
        fmem[k][wptr[k] % 16] = b;
        wptr[k] = wptr[k] + 1;
    endtask

    // Expected line image: start, data LSB first, optional parity, stop bits
    task automatic push_exp(input int k, input logic [7:0] d, input int par_on,
                            input logic par_bit, input int stops, input int gap);
        exp_t e;
        int   n;
        e.k = k; e.bits = '1; e.gap = gap;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1 + i] = d[i];
        n = 9;
        if (par_on != 0) begin e.bits[n] = par_bit; n++; end
        e.nbits = n + stops;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int k, input logic [15:0] target, input int budget);
        int t = 0;
        while (frames_w[k] !== target && t < budget) begin @(negedge clk); t++; end
        check("frames_sent", {16'h0, frames_w[k]}, {16'h0, target});
    endtask

    task automatic wait_tx_low(input int k, input int budget);
        int t = 0;
        while (tx_w[k] !== 1'b0 && t < budget) begin @(negedge clk); t++; end
        check("start_bit_seen", {31'h0, tx_w[k]}, 32'h0);
    endtask

    task automatic monitor(input int k);
        exp_t e;
        int   bad;
        int   s;
        int   t;
        last_end[k] = 0;
        forever begin
            @(negedge clk);
            if (mon_en[k] && !rst && tx_w[k] === 1'b0) begin
                s = cyc;
                if (exp_q.size() == 0 || exp_q[0].k != k) begin
                    check("unexpected_frame", k, 32'hFFFF);
                    t = 0;
                    while (busy_w[k] !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
                end else begin
                    e = exp_q.pop_front();
                    bad = 0;
                    for (int c = 0; c < e.nbits * c_CPB; c++) begin
                        if (c > 0) @(negedge clk);
                        if (tx_w[k] !== e.bits[c / c_CPB] || busy_w[k] !== 1'b1) bad++;
                    end
                    @(negedge clk);
                    check("frame_bits", bad, 0);
                    check("frame_end_busy_tx", {30'h0, busy_w[k], tx_w[k]}, 32'h1);
                    if (e.gap >= 0) check("interframe_gap", s - last_end[k], e.gap);
                    last_end[k] = s + e.nbits * c_CPB;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    initial begin
        int lows;
        int rds;
        int p0;
        for (int k = 0; k < 4; k++) wptr[k] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {28'h0, tx_w}, 32'hF);
        check("reset_busy", {28'h0, busy_w}, 32'h0);
        check("reset_rd_en", {28'h0, rd_en_w}, 32'h0);
        check("reset_frames", {16'h0, frames_w[0]}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 on 8N1 with latency from sampling edge
        en_w[0] = 1'b1;
        push(0, 8'hA5);
        push_exp(0, 8'hA5, 0, 1'b0, 1, -1);
        @(negedge clk);
        check("pop_strobe", {30'h0, rd_en_w[0], tx_w[0]}, 32'h3);
        @(negedge clk);
        check("pop_single", {30'h0, rd_en_w[0], tx_w[0]}, 32'h1);
        @(negedge clk);
        check("start_latency", {31'h0, tx_w[0]}, 32'h0);
        wait_frames(0, 16'd1, 200);
        check("pops_a5", pops[0], 1);

        // three back-to-back frames
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
        push_exp(0, 8'h00, 0, 1'b0, 1, -1);
        push_exp(0, 8'hFF, 0, 1'b0, 1, 3);
        push_exp(0, 8'h55, 0, 1'b0, 1, 3);
        wait_frames(0, 16'd4, 600);
        check("pops_three", pops[0], 4);
        check("fifo_drained", {31'h0, empty_w[0]}, 32'h1);

        // disabled with data waiting
        en_w[0] = 1'b0;
        push(0, 8'h81);
        lows = 0; rds = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) lows++;
            if (rd_en_w[0] !== 1'b0) rds++;
        end
        check("disabled_tx_low_cycles", lows, 0);
        check("disabled_pops", rds, 0);
        en_w[0] = 1'b1;
        push_exp(0, 8'h81, 0, 1'b0, 1, -1);
        wait_frames(0, 16'd5, 200);

        // en dropped during DATA of the first of two queued bytes
        push(0, 8'h12); push(0, 8'h34);
        push_exp(0, 8'h12, 0, 1'b0, 1, -1);
        wait_tx_low(0, 50);
        repeat (30) @(negedge clk);
        en_w[0] = 1'b0;
        wait_frames(0, 16'd6, 200);
        repeat (200) @(negedge clk);
        check("en_drop_pops", pops[0], 6);
        check("en_drop_left", {31'h0, empty_w[0]}, 32'h0);

        // reset at cycle 40 of a frame abandons it
        mon_en[0] = 1'b0;
        en_w[0] = 1'b1;
        wait_tx_low(0, 50);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", {12'h0, frames_w[0], 1'b0, tx_w[0], busy_w[0], rd_en_w[0]}, 32'h4);
        mon_en[0] = 1'b1;
        push(0, 8'h3C);
        push_exp(0, 8'h3C, 0, 1'b0, 1, -1);
        wait_frames(0, 16'd1, 200);

        // frame counter wrap
        @(negedge clk);
        force dut0.r_frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut0.r_frames_sent;
        p0 = pops[0];
        push(0, 8'h5A);
        push_exp(0, 8'h5A, 0, 1'b0, 1, -1);
        wait_frames(0, 16'd0, 200);
        check("wrap_pops", pops[0], p0 + 1);

        // parity and two stop bits
        en_w[3:1] = 3'b111;
        push(1, 8'h07); push_exp(1, 8'h07, 1, 1'b1, 1, -1);
        wait_frames(1, 16'd1, 300);
        push(1, 8'h03); push_exp(1, 8'h03, 1, 1'b0, 1, -1);
        wait_frames(1, 16'd2, 300);
        push(2, 8'h07); push_exp(2, 8'h07, 1, 1'b0, 1, -1);
        wait_frames(2, 16'd1, 300);
        push(2, 8'h03); push_exp(2, 8'h03, 1, 1'b1, 1, -1);
        wait_frames(2, 16'd2, 300);
        push(3, 8'h07); push_exp(3, 8'h07, 0, 1'b0, 2, -1);
        wait_frames(3, 16'd1, 300);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("pop_on_empty", bad_pops[0] + bad_pops[1] + bad_pops[2] + bad_pops[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
